// File: rtl/game_controller.sv
// game_controller: game-flow FSM with ship/enemy-ball collision detection, lives and saturating score.
// Drives pausa/reiniciarJogo back to the entity stage.
module game_controller #(
  parameter int VIDAS_INICIAIS     = 3,
  parameter int INVULN_CICLOS      = 25000000,
  parameter int PONTOS_POR_INIMIGO = 10,
  parameter int PONTOS_MAX         = 9999,
  parameter int RESTART_CICLOS     = 4
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        iniciar,
  input  logic        botao_pausa,
  input  logic [9:0]  x_nave,
  input  logic [9:0]  y_nave,
  input  logic [9:0]  largura_nave,
  input  logic [9:0]  altura_nave,
  input  logic [9:0]  x_bola_inimiga,
  input  logic [9:0]  y_bola_inimiga,
  input  logic [9:0]  raio_bola_inimiga,
  input  logic        inimigo_vivo,
  output logic        pausa,
  output logic        reiniciarJogo,
  output logic [2:0]  vidas,
  output logic [13:0] pontos,
  output logic        game_over,
  output logic [2:0]  estado
);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RESTART   = 3'd1,
    PLAYING   = 3'd2,
    HIT       = 3'd3,
    PAUSED    = 3'd4,
    GAME_OVER = 3'd5
  } state_t;
  localparam int CMAX = INVULN_CICLOS > RESTART_CICLOS ? INVULN_CICLOS : RESTART_CICLOS;
  localparam int CW = $clog2(CMAX + 1) + 1;
  localparam logic [CW-1:0] INV_LOAD = CW'(INVULN_CICLOS > 0 ? INVULN_CICLOS - 1 : 0);
  localparam logic [CW-1:0] RST_LOAD = CW'(RESTART_CICLOS > 0 ? RESTART_CICLOS - 1 : 0);
  logic [10:0]   bx_lo, bx_hi, by_lo, by_hi, sx_lo, sx_hi, sy_lo, sy_hi;
  logic          colisao_d, colisao_q;
  logic          iniciar_q, botao_q, vivo_q;
  logic          iniciar_ev_q, pausa_ev_q, kill_ev_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    vidas_q, vidas_d;
  logic [13:0]   pontos_q, pontos_d;
  logic [14:0]   psum;
  logic          pausa_q, reiniciar_q, game_over_q;
  // Ball box low edges clamp at 0 so a ball near the left/top border cannot wrap to a far coordinate
  always_comb begin
    sx_lo = {1'b0, x_nave};
    sx_hi = sx_lo + {1'b0, largura_nave} - 11'd1;
    sy_lo = {1'b0, y_nave};
    sy_hi = sy_lo + {1'b0, altura_nave} - 11'd1;
    bx_lo = x_bola_inimiga >= raio_bola_inimiga ? {1'b0, x_bola_inimiga - raio_bola_inimiga} : '0;
    by_lo = y_bola_inimiga >= raio_bola_inimiga ? {1'b0, y_bola_inimiga - raio_bola_inimiga} : '0;
    bx_hi = {1'b0, x_bola_inimiga} + {1'b0, raio_bola_inimiga};
    by_hi = {1'b0, y_bola_inimiga} + {1'b0, raio_bola_inimiga};
    colisao_d = bx_lo <= sx_hi && bx_hi >= sx_lo && by_lo <= sy_hi && by_hi >= sy_lo;
  end
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      iniciar_q    <= 1'b0;
      botao_q      <= 1'b0;
      vivo_q       <= 1'b0;
      iniciar_ev_q <= 1'b0;
      pausa_ev_q   <= 1'b0;
      kill_ev_q    <= 1'b0;
      colisao_q    <= 1'b0;
    end else begin
      iniciar_q    <= iniciar;
      botao_q      <= botao_pausa;
      vivo_q       <= inimigo_vivo;
      iniciar_ev_q <= iniciar & ~iniciar_q;
      pausa_ev_q   <= botao_pausa & ~botao_q;
      kill_ev_q    <= vivo_q & ~inimigo_vivo;
      colisao_q    <= colisao_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    vidas_d  = vidas_q;
    pontos_d = pontos_q;
    psum     = {1'b0, pontos_q} + 15'(PONTOS_POR_INIMIGO);
    case (state_q)
      IDLE:      state_d = iniciar_ev_q ? RESTART : IDLE;
      RESTART: begin
        state_d = cnt_q == '0 ? PLAYING : RESTART;
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
      end
      PLAYING: begin
        if (colisao_q) begin
          vidas_d = vidas_q > 3'd1 ? vidas_q - 3'd1 : 3'd0;
          state_d = vidas_q > 3'd1 ? HIT : GAME_OVER;
          cnt_d   = INV_LOAD;
        end else if (pausa_ev_q) begin
          state_d = PAUSED;
        end
      end
      HIT: begin
        state_d = cnt_q == '0 ? PLAYING : HIT;
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
      end
      PAUSED:    state_d = pausa_ev_q ? PLAYING : PAUSED;
      GAME_OVER: state_d = iniciar_ev_q ? RESTART : GAME_OVER;
      default:   state_d = IDLE;
    endcase
    if (kill_ev_q && (state_q == PLAYING || state_q == HIT))
      pontos_d = psum > 15'(PONTOS_MAX) ? 14'(PONTOS_MAX) : psum[13:0];
    if (state_d == RESTART && state_q != RESTART) begin
      cnt_d    = RST_LOAD;
      vidas_d  = 3'(VIDAS_INICIAIS);
      pontos_d = '0;
    end
  end
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      vidas_q     <= 3'(VIDAS_INICIAIS);
      pontos_q    <= '0;
      pausa_q     <= 1'b1;
      reiniciar_q <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vidas_q     <= vidas_d;
      pontos_q    <= pontos_d;
      pausa_q     <= state_d inside {IDLE, RESTART, PAUSED, GAME_OVER};
      reiniciar_q <= state_d == RESTART;
      game_over_q <= state_d == GAME_OVER;
    end
  end
  assign pausa         = pausa_q;
  assign reiniciarJogo = reiniciar_q;
  assign vidas         = vidas_q;
  assign pontos        = pontos_q;
  assign game_over     = game_over_q;
  assign estado        = state_q;
endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: table-driven collision vectors, directed game-flow sequences and a
// randomized run checked every cycle against a behavioural model of the game rules.
module tb_game_controller;
  localparam int VI   = 3;
  localparam int IC   = 20;
  localparam int RC   = 4;
  localparam int PPI  = 10;
  localparam int PMAX = 9999;
  logic        clk = 1'b0;
  logic        reset, iniciar, botao_pausa, inimigo_vivo;
  logic [9:0]  x_nave, y_nave, largura_nave, altura_nave;
  logic [9:0]  x_bola_inimiga, y_bola_inimiga, raio_bola_inimiga;
  logic        pausa, reiniciarJogo, game_over;
  logic [2:0]  vidas, estado;
  logic [13:0] pontos;
  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;
  always #5 clk = ~clk;
  game_controller #(
    .VIDAS_INICIAIS(VI), .INVULN_CICLOS(IC), .PONTOS_POR_INIMIGO(PPI),
    .PONTOS_MAX(PMAX), .RESTART_CICLOS(RC)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .iniciar(iniciar), .botao_pausa(botao_pausa),
    .x_nave(x_nave), .y_nave(y_nave), .largura_nave(largura_nave), .altura_nave(altura_nave),
    .x_bola_inimiga(x_bola_inimiga), .y_bola_inimiga(y_bola_inimiga),
    .raio_bola_inimiga(raio_bola_inimiga), .inimigo_vivo(inimigo_vivo),
    .pausa(pausa), .reiniciarJogo(reiniciarJogo), .vidas(vidas), .pontos(pontos),
    .game_over(game_over), .estado(estado)
  );
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  function automatic bit overlap(input int sx, input int sy, input int w, input int h,
                                 input int bx, input int by, input int r);
    int lx, ly;
    lx = bx - r < 0 ? 0 : bx - r;
    ly = by - r < 0 ? 0 : by - r;
    return lx <= sx + w - 1 && bx + r >= sx && ly <= sy + h - 1 && by + r >= sy;
  endfunction
  // Behavioural model: game mode, lives, score and the cycles left in a timed phase
  int m_mode, m_vidas, m_pontos, m_left;
  bit p_ini, p_pau, p_viv, e_ini, e_pau, e_kill, e_col;
  bit n_ini, n_pau, n_kill, n_col;
  always @(posedge clk) begin
    if (!reset) begin
      m_mode = 0; m_vidas = VI; m_pontos = 0; m_left = 0;
      {p_ini, p_pau, p_viv, e_ini, e_pau, e_kill, e_col} = '0;
    end else begin
      n_ini  = iniciar && !p_ini;
      n_pau  = botao_pausa && !p_pau;
      n_kill = p_viv && !inimigo_vivo;
      n_col  = overlap(x_nave, y_nave, largura_nave, altura_nave,
                       x_bola_inimiga, y_bola_inimiga, raio_bola_inimiga);
      if (e_kill && (m_mode == 2 || m_mode == 3))
        m_pontos = m_pontos + PPI > PMAX ? PMAX : m_pontos + PPI;
      case (m_mode)
        0, 5: if (e_ini) begin m_mode = 1; m_left = RC; m_vidas = VI; m_pontos = 0; end
        1, 3: begin m_left--; if (m_left <= 0) m_mode = 2; end
        2: if (e_col) begin
             m_vidas--;
             if (m_vidas == 0) m_mode = 5;
             else begin m_mode = 3; m_left = IC; end
           end else if (e_pau) m_mode = 4;
        4: if (e_pau) m_mode = 2;
        default: m_mode = 0;
      endcase
      p_ini = iniciar; p_pau = botao_pausa; p_viv = inimigo_vivo;
      e_ini = n_ini; e_pau = n_pau; e_kill = n_kill; e_col = n_col;
    end
  end
  always @(negedge clk) if (mon_en) begin
    chk("mon_estado", estado, m_mode);
    chk("mon_vidas", vidas, m_vidas);
    chk("mon_pontos", pontos, m_pontos);
    chk("mon_pausa", pausa, (m_mode == 0 || m_mode == 1 || m_mode == 4 || m_mode == 5));
    chk("mon_reiniciar", reiniciarJogo, m_mode == 1);
    chk("mon_game_over", game_over, m_mode == 5);
  end
  typedef struct {
    int sx, sy, w, h, bx, by, r;
    bit col;
  } cvec_t;
  cvec_t cv[11];
  task automatic set_geom(input int sx, input int sy, input int w, input int h,
                          input int bx, input int by, input int r);
    x_nave = 10'(sx); y_nave = 10'(sy); largura_nave = 10'(w); altura_nave = 10'(h);
    x_bola_inimiga = 10'(bx); y_bola_inimiga = 10'(by); raio_bola_inimiga = 10'(r);
  endtask
  task automatic set_far();
    set_geom(600, 400, 40, 20, 0, 0, 0);
  endtask
  task automatic set_hit();
    set_geom(100, 400, 40, 20, 120, 395, 5);
  endtask
  task automatic pulse_ini();
    iniciar = 1'b1; @(negedge clk); iniciar = 1'b0;
  endtask
  task automatic pulse_pau();
    botao_pausa = 1'b1; @(negedge clk); botao_pausa = 1'b0;
  endtask
  task automatic kill();
    inimigo_vivo = 1'b1; @(negedge clk); inimigo_vivo = 1'b0; @(negedge clk);
  endtask
  task automatic wait_estado(input int s, input int budget, input string nm);
    int n = 0;
    while (int'(estado) != s && n < budget) begin @(negedge clk); n++; end
    chk(nm, estado, s);
  endtask
  initial begin
    int n;
    cv[0]  = '{100, 400, 40, 20, 120, 395, 5, 1'b1};
    cv[1]  = '{0, 100, 10, 10, 3, 105, 5, 1'b1};
    cv[2]  = '{600, 400, 40, 20, 0, 0, 0, 1'b0};
    cv[3]  = '{100, 400, 40, 20, 94, 410, 5, 1'b0};
    cv[4]  = '{100, 400, 40, 20, 95, 410, 5, 1'b1};
    cv[5]  = '{100, 400, 40, 20, 145, 410, 5, 1'b0};
    cv[6]  = '{100, 400, 40, 20, 144, 410, 5, 1'b1};
    cv[7]  = '{100, 400, 40, 20, 120, 394, 5, 1'b0};
    cv[8]  = '{100, 400, 40, 20, 120, 424, 5, 1'b1};
    cv[9]  = '{0, 0, 1, 1, 1023, 1023, 1023, 1'b1};
    cv[10] = '{1000, 1000, 23, 23, 5, 5, 5, 1'b0};
    reset = 1'b0; iniciar = 1'b0; botao_pausa = 1'b0; inimigo_vivo = 1'b0;
    set_far();
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    chk("rst_estado", estado, 0);
    chk("rst_vidas", vidas, VI);
    chk("rst_pontos", pontos, 0);
    chk("rst_pausa", pausa, 1);
    chk("rst_reiniciar", reiniciarJogo, 0);
    chk("rst_game_over", game_over, 0);
    reset = 1'b1;
    foreach (cv[i]) begin
      set_geom(cv[i].sx, cv[i].sy, cv[i].w, cv[i].h, cv[i].bx, cv[i].by, cv[i].r);
      @(negedge clk);
      chk($sformatf("colisao_vec%0d", i), dut.colisao_q, cv[i].col);
    end
    set_far();
    pulse_ini();
    n = 0;
    for (int i = 0; i < 30; i++) begin @(negedge clk); if (reiniciarJogo) n++; end
    chk("restart_len", n, RC);
    chk("start_estado", estado, 2);
    chk("start_pausa", pausa, 0);
    chk("start_vidas", vidas, VI);
    chk("start_pontos", pontos, 0);
    repeat (3) kill();
    repeat (2) @(negedge clk);
    chk("three_kills", pontos, 3 * PPI);
    pulse_pau();
    repeat (3) @(negedge clk);
    chk("paused_estado", estado, 4);
    chk("paused_pausa", pausa, 1);
    kill();
    repeat (2) @(negedge clk);
    chk("paused_kill_dropped", pontos, 3 * PPI);
    pulse_pau();
    repeat (3) @(negedge clk);
    chk("unpause_estado", estado, 2);
    set_hit();
    wait_estado(3, 10, "hit_entry");
    chk("hit_vidas", vidas, 2);
    n = 0;
    while (estado == 3'd3 && n < 100) begin
      botao_pausa = (n == 5);
      n++;
      @(negedge clk);
    end
    botao_pausa = 1'b0;
    chk("hit_len", n, IC);
    chk("hit_exit_estado", estado, 2);
    chk("hit_exit_vidas", vidas, 2);
    @(negedge clk);
    chk("rehit_estado", estado, 3);
    chk("rehit_vidas", vidas, 1);
    wait_estado(5, 100, "gameover_entry");
    chk("gameover_vidas", vidas, 0);
    chk("gameover_flag", game_over, 1);
    chk("gameover_pausa", pausa, 1);
    set_far();
    pulse_ini();
    wait_estado(1, 10, "restart_entry");
    chk("restart_vidas", vidas, VI);
    chk("restart_pontos", pontos, 0);
    chk("restart_game_over", game_over, 0);
    wait_estado(2, 20, "replay_entry");
    repeat (999) kill();
    repeat (2) @(negedge clk);
    chk("score_9990", pontos, 9990);
    kill();
    repeat (2) @(negedge clk);
    chk("score_sat", pontos, PMAX);
    kill();
    repeat (2) @(negedge clk);
    chk("score_sat_hold", pontos, PMAX);
    set_hit();
    wait_estado(3, 10, "hit2_entry");
    repeat (3) @(negedge clk);
    reset = 1'b0; @(negedge clk); reset = 1'b1;
    chk("midhit_rst_estado", estado, 0);
    chk("midhit_rst_vidas", vidas, VI);
    chk("midhit_rst_pontos", pontos, 0);
    set_far();
    pulse_ini();
    wait_estado(1, 10, "restart2_entry");
    reset = 1'b0; @(negedge clk); reset = 1'b1;
    chk("midrestart_rst_estado", estado, 0);
    chk("midrestart_rst_reiniciar", reiniciarJogo, 0);
    for (int i = 0; i < 4000; i++) begin
      reset = $urandom_range(0, 599) != 0;
      iniciar = $urandom_range(0, 29) == 0;
      botao_pausa = $urandom_range(0, 39) == 0;
      if ($urandom_range(0, 3) == 0) inimigo_vivo = ~inimigo_vivo;
      if ($urandom_range(0, 7) == 0)
        set_geom($urandom_range(0, 100), $urandom_range(0, 100), $urandom_range(1, 40),
                 $urandom_range(1, 40), $urandom_range(0, 150), $urandom_range(0, 150),
                 $urandom_range(0, 20));
      @(negedge clk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
